// File: rtl/framebuffer_loader_if.sv
// Byte-stream input and BRAM write port of the framebuffer loader.
// master = upstream byte source / BRAM observer, slave = the loader itself.
interface framebuffer_loader_if #(
    parameter int ADDR_WIDTH = 15
);
    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [63:0]           bram_data;
    logic                  bram_we;

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, bram_addr, bram_data, bram_we
    );

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, bram_addr, bram_data, bram_we
    );
endinterface

// File: rtl/framebuffer_loader.sv
// Parses SOF/length/point-record frames into 64-bit point words written to the framebuffer BRAM.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module framebuffer_loader #(
    parameter int         ADDR_WIDTH = 15,
    parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    framebuffer_loader_if.slave  bus,
    output logic [15:0]          frame_points,
    output logic                 frame_done,
    output logic                 len_err,
    output logic                 sum_err,
    output logic                 busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd5;
`ifdef CHECKSUM_EN
    localparam logic [2:0] S_CHECK   = 3'd4;
`endif

    localparam logic [31:0] MAX_POINTS = 32'd1 << ADDR_WIDTH;

    logic [2:0]            state;
    logic [15:0]           frame_len;
    logic [2:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] point_ctr;
    logic [ADDR_WIDTH-1:0] last_point;
    logic [47:0]           assembly;
    logic                  xfer;
    logic [15:0]           len_new;
`ifdef CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign xfer           = bus.byte_valid && bus.byte_ready;
    assign len_new        = {frame_len[15:8], bus.byte_data};
    assign bus.byte_ready = rst_n && (state != S_DONE);
    assign busy           = (state != S_IDLE);

`ifndef CHECKSUM_EN
    assign sum_err = 1'b0;
`endif

    // NOTE: all state here is sequential, so every assignment in this block is non-blocking;
    // the per-cycle strobes default low first and are raised only where a branch needs them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            frame_len     <= '0;
            byte_idx      <= '0;
            point_ctr     <= '0;
            last_point    <= '0;
            assembly      <= '0;
            bus.bram_addr <= '0;
            bus.bram_data <= '0;
            bus.bram_we   <= 1'b0;
            frame_points  <= '0;
            frame_done    <= 1'b0;
            len_err       <= 1'b0;
`ifdef CHECKSUM_EN
            csum          <= '0;
            sum_err       <= 1'b0;
`endif
        end else begin
            bus.bram_we <= 1'b0;
            frame_done  <= 1'b0;
            len_err     <= 1'b0;
`ifdef CHECKSUM_EN
            sum_err     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (xfer && bus.byte_data == SOF_BYTE) begin
                        state <= S_LEN_HI;
`ifdef CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        frame_len[15:8] <= bus.byte_data;
                        state           <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (xfer) begin
                        frame_len[7:0] <= bus.byte_data;
                        if (len_new == 16'd0) begin
`ifdef CHECKSUM_EN
                            state        <= S_CHECK;
`else
                            state        <= S_DONE;
                            frame_done   <= 1'b1;
                            frame_points <= 16'd0;
`endif
                        end else if (32'(len_new) > MAX_POINTS) begin
                            len_err <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            byte_idx   <= '0;
                            point_ctr  <= '0;
                            last_point <= ADDR_WIDTH'(len_new - 16'd1);
                            state      <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (xfer) begin
`ifdef CHECKSUM_EN
                        csum <= csum ^ bus.byte_data;
`endif
                        if (byte_idx == 3'd6) begin
                            // Colour bytes arrive first-to-last into [7:0], [15:8], [23:16].
                            bus.bram_we   <= 1'b1;
                            bus.bram_addr <= point_ctr;
                            bus.bram_data <= {8'h00, assembly[47:16], bus.byte_data,
                                              assembly[7:0], assembly[15:8]};
                            byte_idx      <= '0;
                            point_ctr     <= point_ctr + 1'b1;
                            if (point_ctr == last_point) begin
`ifdef CHECKSUM_EN
                                state        <= S_CHECK;
`else
                                state        <= S_DONE;
                                frame_done   <= 1'b1;
                                frame_points <= frame_len;
`endif
                            end
                        end else begin
                            assembly <= {assembly[39:0], bus.byte_data};
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end

`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        if (bus.byte_data == csum) begin
                            state        <= S_DONE;
                            frame_done   <= 1'b1;
                            frame_points <= frame_len;
                        end else begin
                            sum_err <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
`endif

                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
